// File: rtl/cdtimer_pkg.sv
// cdtimer_pkg: shared address map and CTL bit positions for the countdown timer.
package cdtimer_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam logic [ADDR_WIDTH-1:0] TIMER_CNT_ADDR = ADDR_WIDTH'(16'h002);
    localparam logic [ADDR_WIDTH-1:0] TIMER_CTL_ADDR = ADDR_WIDTH'(16'h004);
    localparam int TIMER_IF = 0;
    localparam int TIMER_IE = 1;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick at TICK_HZ.
module tick_gen #(
    parameter int CLOCK_HZ = 27_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLOCK_HZ / TICK_HZ;
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] RELOAD = W'(DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= RELOAD;
        else cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
    assign tick = cnt == '0;
endmodule

// File: rtl/cdtimer.sv
// cdtimer: memory-mapped 16-bit countdown timer (CNT at 002h, CTL at 004h) with
// interrupt flag/enable and registered read data for the shared CPU bus.
module cdtimer
    import cdtimer_pkg::*;
#(
    parameter int CLOCK_HZ = 27_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  wr_mem,
    input  logic                  byt,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data,
    output logic                  irq
);
    logic        tick;
    logic [15:0] cnt, cnt_n;
    logic        if_r, ie_r, if_n, ie_n;
    logic        sel_cnt, sel_ctl, cnt_wr, ctl_wr, wr_lo, wr_hi, expire;

    tick_gen #(.CLOCK_HZ(CLOCK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        sel_cnt = mem_addr[ADDR_WIDTH-1:1] == TIMER_CNT_ADDR[ADDR_WIDTH-1:1];
        sel_ctl = mem_addr[ADDR_WIDTH-1:1] == TIMER_CTL_ADDR[ADDR_WIDTH-1:1];
        cnt_wr  = wr_mem & sel_cnt;
        ctl_wr  = wr_mem & sel_ctl & ~(byt & mem_addr[0]);
        wr_lo   = cnt_wr & (~byt | ~mem_addr[0]);
        wr_hi   = cnt_wr & (~byt | mem_addr[0]);
        // A bus write to CNT always beats the tick, so expiry is suppressed then.
        expire  = tick & ~cnt_wr & (cnt == 16'd1);
        cnt_n   = cnt_wr ? {wr_hi ? wr_data[15:8] : cnt[15:8], wr_lo ? wr_data[7:0] : cnt[7:0]}
                : (tick && cnt != 16'd0) ? cnt - 16'd1 : cnt;
        if_n    = (ctl_wr ? wr_data[TIMER_IF] : if_r) | expire;
        ie_n    = ctl_wr ? wr_data[TIMER_IE] : ie_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            if_r    <= 1'b0;
            ie_r    <= 1'b0;
            rd_data <= '0;
            irq     <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            if_r    <= if_n;
            ie_r    <= ie_n;
            rd_data <= sel_cnt ? cnt : sel_ctl ? {14'b0, ie_r, if_r} : 16'h0;
            irq     <= if_r & ie_r;
        end
    end
endmodule

// File: tb/tb_cdtimer.sv
// tb_cdtimer: directed stimulus against a cycle-level behavioural model of the timer.
module tb_cdtimer;
    import cdtimer_pkg::*;

    logic                  clk = 0;
    logic                  rst = 1;
    logic [ADDR_WIDTH-1:0] mem_addr = '0;
    logic                  wr_mem = 0;
    logic                  byt = 0;
    logic [15:0]           wr_data = '0;
    logic [15:0]           rd_data;
    logic                  irq;

    int total = 0;
    int bad = 0;

    cdtimer #(.CLOCK_HZ(10000), .TICK_HZ(1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .wr_mem   (wr_mem),
        .byt      (byt),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Model: k counts edges since reset, a tick lands on every tenth edge.
    int          k = 0;
    logic [15:0] m_cnt = 0, m_rd = 0;
    logic        m_if = 0, m_ie = 0, m_irq = 0, chk = 0;
    int          reg_idx;
    logic        hw_set;

    always @(posedge clk) begin
        chk = 1;
        if (rst) begin
            k = 0; m_cnt = 0; m_if = 0; m_ie = 0; m_irq = 0; m_rd = 0;
        end else begin
            k++;
            reg_idx = int'(mem_addr) / 2;
            m_rd = reg_idx == 1 ? m_cnt : reg_idx == 2 ? {14'b0, m_ie, m_if} : 16'h0;
            m_irq = m_if & m_ie;
            hw_set = 0;
            if (wr_mem && reg_idx == 1) begin
                if (!byt || !mem_addr[0]) m_cnt[7:0] = wr_data[7:0];
                if (!byt || mem_addr[0]) m_cnt[15:8] = wr_data[15:8];
            end else if (k % 10 == 0 && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                hw_set = m_cnt == 0;
            end
            if (wr_mem && reg_idx == 2 && !(byt && mem_addr[0])) begin
                m_if = wr_data[0];
                m_ie = wr_data[1];
            end
            m_if = m_if | hw_set;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            total++;
            if (rd_data !== m_rd || irq !== m_irq) begin
                bad++;
                $display("FAIL model t=%0t: rd_data=%h irq=%b, want rd_data=%h irq=%b",
                         $time, rd_data, irq, m_rd, m_irq);
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic w, input logic b);
        mem_addr = ADDR_WIDTH'(a);
        wr_data = d;
        wr_mem = w;
        byt = b;
        @(posedge clk);
        #1;
        mem_addr = '0;
        wr_mem = 0;
        byt = 0;
        wr_data = '0;
    endtask

    // Returns with the next edge being a tick edge.
    task automatic wait_tick();
        int n = 0;
        while ((k + 1) % 10 != 0 && n < 20) begin
            bus(0, 0, 0, 0);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL wait_tick: no tick within 20 cycles");
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        bus(16'h002, 0, 0, 0);
        check("rd_cnt_rst", rd_data, 16'h0000);
        bus(16'h004, 0, 0, 0);
        check("rd_ctl_rst", rd_data, 16'h0000);
        check("irq_rst", {15'b0, irq}, 16'h0);

        wait_tick();
        bus(0, 0, 0, 0);
        bus(16'h002, 16'h0003, 1, 0);
        bus(16'h004, 16'h0002, 1, 0);
        wait_tick(); bus(0, 0, 0, 0); bus(16'h002, 0, 0, 0);
        check("cnt_2", rd_data, 16'h0002);
        wait_tick(); bus(0, 0, 0, 0); bus(16'h002, 0, 0, 0);
        check("cnt_1", rd_data, 16'h0001);
        check("irq_before_exp", {15'b0, irq}, 16'h0);
        wait_tick(); bus(0, 0, 0, 0); bus(16'h002, 0, 0, 0);
        check("cnt_0", rd_data, 16'h0000);
        check("irq_exp", {15'b0, irq}, 16'h1);
        repeat (50) bus(0, 0, 0, 0);
        bus(16'h002, 0, 0, 0);
        check("cnt_no_wrap", rd_data, 16'h0000);
        check("irq_held", {15'b0, irq}, 16'h1);

        bus(16'h004, 16'h0002, 1, 0);
        bus(0, 0, 0, 0);
        check("irq_ack", {15'b0, irq}, 16'h0);
        bus(16'h004, 16'h0003, 1, 0);
        bus(0, 0, 0, 0);
        check("irq_sw_set", {15'b0, irq}, 16'h1);

        wait_tick();
        bus(0, 0, 0, 0);
        bus(16'h002, 16'h0034, 1, 1);
        bus(16'h003, 16'h1200, 1, 1);
        bus(16'h002, 0, 0, 0);
        check("cnt_bytes", rd_data, 16'h1234);
        bus(16'h005, 16'h0000, 1, 1);
        bus(16'h004, 0, 0, 0);
        check("ctl_byte5", rd_data, 16'h0003);

        bus(16'h004, 16'h0002, 1, 0);
        wait_tick();
        bus(0, 0, 0, 0);
        bus(16'h002, 16'h0001, 1, 0);
        wait_tick();
        bus(16'h002, 16'h0005, 1, 0);
        bus(16'h004, 0, 0, 0);
        check("wr_wins_ctl", rd_data, 16'h0002);
        bus(16'h002, 0, 0, 0);
        check("wr_wins_cnt", rd_data, 16'h0005);
        check("wr_wins_irq", {15'b0, irq}, 16'h0);
        bus(16'h002, 16'h0001, 1, 0);
        wait_tick();
        bus(16'h004, 16'h0002, 1, 0);
        bus(16'h004, 0, 0, 0);
        check("hw_wins_ctl", rd_data, 16'h0003);
        check("hw_wins_irq", {15'b0, irq}, 16'h1);

        bus(16'h002, 16'h0007, 1, 0);
        bus(16'h004, 16'h0003, 1, 0);
        bus(0, 0, 0, 0);
        mem_addr = ADDR_WIDTH'(16'h002);
        rst = 1;
        @(posedge clk);
        #1;
        check("rst_rd", rd_data, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0);
        rst = 0;
        mem_addr = '0;
        bus(16'h002, 0, 0, 0);
        check("rst_cnt", rd_data, 16'h0000);
        bus(16'h002, 16'h0001, 1, 0);
        bus(16'h004, 16'h0002, 1, 0);
        repeat (7) bus(0, 0, 0, 0);
        check("presc_no_early", {15'b0, irq}, 16'h0);
        bus(0, 0, 0, 0);
        check("presc_tick10", {15'b0, irq}, 16'h1);

        repeat (3) bus(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
